sm_rle: RTL

Run-length encoder sitting directly downstream of `sm_dut`; consumes its valid-only `o_dval`/`o` word stream. It collapses consecutive identical words into (value, count) pairs and buffers them in a small first-word-fall-through FIFO. The FIFO drains through a valid/ready output port. The upstream stream has no backpressure, so FIFO overflow is detected and flagged rather than stalled.

---
 rtl/sm_rle.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sm_rle.sv
// Run-length encoder: folds repeated input words into (value, count) runs and buffers them in a FWFT FIFO.
// Optional `SM_RLE_LEVEL_EN adds an o_level port reporting FIFO occupancy.
module sm_rle #(
   parameter int IW    = 8,
   parameter int CW    = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_dval,
   input  logic [IW-1:0]            i,
   input  logic                     i_flush,
   output logic                     o_val,
   input  logic                     o_rdy,
   output logic [IW-1:0]            o_dat,
   output logic [CW-1:0]            o_cnt,
`ifdef SM_RLE_LEVEL_EN
   output logic [$clog2(DEPTH):0]   o_level,
`endif
   output logic                     o_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [CW-1:0] MAX = '1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IW-1:0]   r_cur;
   logic [IW-1:0]   w_cur_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_pend;
   logic            w_pend_nxt;
   logic            w_push;

   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic            r_ovf;
   logic [IW-1:0]   r_mem_dat [DEPTH];
   logic [CW-1:0]   r_mem_cnt [DEPTH];
   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_wr;
   logic            w_drop;

   // Run tracker. A flush that coincides with a valid word is parked in r_pend
   // and executed on the next idle input cycle, so at most one push per cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      w_push      = 1'b0;
      if (i_dval) begin
         w_pend_nxt = r_pend | i_flush;
         if (r_state == ST_IDLE) begin
            w_state_nxt = ST_RUN;
            w_cur_nxt   = i;
            w_cnt_nxt   = CW'(1);
         end else if ((i == r_cur) && (r_cnt != MAX)) begin
            w_cnt_nxt = r_cnt + CW'(1);
         end else begin
            w_push    = 1'b1;
            w_cur_nxt = i;
            w_cnt_nxt = CW'(1);
         end
      end else if (i_flush || r_pend) begin
         w_pend_nxt = 1'b0;
         if (r_state == ST_RUN) begin
            w_push      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cur   <= '0;
         r_cnt   <= '0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cur   <= w_cur_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   // Output handshake: an entry transfers on every rising edge where o_val && o_rdy;
   // o_val never depends on o_rdy and head data holds while o_val && !o_rdy.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop   = !w_empty && o_rdy;
   assign w_wr    = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem_dat[r_wptr[AW-1:0]] <= r_cur;
         r_mem_cnt[r_wptr[AW-1:0]] <= r_cnt;
      end
   end

   // Head fields are forced to zero when empty so reset clears them without resetting the array.
   assign o_val = !w_empty;
   assign o_dat = w_empty ? '0 : r_mem_dat[r_rptr[AW-1:0]];
   assign o_cnt = w_empty ? '0 : r_mem_cnt[r_rptr[AW-1:0]];
   assign o_ovf = r_ovf;
`ifdef SM_RLE_LEVEL_EN
   assign o_level = r_wptr - r_rptr;
`endif

endmodule
